// File: rtl/mem_tlb_walker.sv
// mem_tlb_walker
//   Hardware page-table walker. On a TLB miss it reads TTB from the TLB
//   register file, walks a fixed 4-level in-memory page table, writes
//   PTEH/PTEL and issues LDTLB. Invalid entries, bus errors or memory
//   timeouts load TEA with the faulting VA and pulse walkFault.
//
// Ports
//   clk, reset        clock, synchronous active-low reset
//   missReq/missAddr  walk request and faulting VA (sampled in IDLE)
//   tlbOpMode/Reg     TLB op (0 none, 2 getreg, 3 setreg, 4 ldtlb) / reg select
//   tlbInAddr         setreg data; tlbOutAddr is the combinational getreg result
//   memAddr/memOE     PTE read address and read request
//   memData/OK/Err    read data, completion and bus error
//   walkBusy          high whenever the walker is not idle
//   walkDone/Fault    one-cycle completion / abort pulses
//
// state    | meaning
// ---------+---------------------------------------------------------
// IDLE     | waiting for missReq
// GETTTB   | reading TTB from the TLB register file
// MEMRD    | PTE read outstanding, timer running
// CHECK    | examine fetched PTE, descend or finish
// SETPTEH  | write PTEH with the VPN of the faulting VA
// SETPTEL  | write PTEL with the leaf PTE
// LDTLB    | load the TLB entry from PTEH/PTEL
// DONE     | walkDone pulse
// SETTEA   | write TEA with the faulting VA
// FAULT    | walkFault pulse

module mem_tlb_walker #(
    parameter int TIMEOUT   = 255,
    parameter int VALID_BIT = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        missReq,
    input  logic [63:0] missAddr,
    output logic [2:0]  tlbOpMode,
    output logic [2:0]  tlbOpReg,
    output logic [63:0] tlbInAddr,
    input  logic [63:0] tlbOutAddr,
    output logic [39:0] memAddr,
    output logic        memOE,
    input  logic [63:0] memData,
    input  logic        memOK,
    input  logic        memErr,
    output logic        walkBusy,
    output logic        walkDone,
    output logic        walkFault
);

    localparam logic [3:0] S_IDLE    = 4'd0;
    localparam logic [3:0] S_GETTTB  = 4'd1;
    localparam logic [3:0] S_MEMRD   = 4'd2;
    localparam logic [3:0] S_CHECK   = 4'd3;
    localparam logic [3:0] S_SETPTEH = 4'd4;
    localparam logic [3:0] S_SETPTEL = 4'd5;
    localparam logic [3:0] S_LDTLB   = 4'd6;
    localparam logic [3:0] S_DONE    = 4'd7;
    localparam logic [3:0] S_SETTEA  = 4'd8;
    localparam logic [3:0] S_FAULT   = 4'd9;

    localparam logic [2:0] OP_NONE   = 3'd0;
    localparam logic [2:0] OP_GETREG = 3'd2;
    localparam logic [2:0] OP_SETREG = 3'd3;
    localparam logic [2:0] OP_LDTLB  = 3'd4;

    localparam logic [2:0] R_NONE = 3'd0;
    localparam logic [2:0] R_PTEH = 3'd1;
    localparam logic [2:0] R_PTEL = 3'd2;
    localparam logic [2:0] R_TTB  = 3'd3;
    localparam logic [2:0] R_TEA  = 3'd4;

    // The 8-bit timer can only express limits 1..255.
    localparam int         TO_LIM = (TIMEOUT < 1) ? 1 : ((TIMEOUT > 255) ? 255 : TIMEOUT);
    localparam logic [7:0] TO_CNT = 8'(TO_LIM);

    logic [3:0]  state_q, state_d;
    logic [63:0] va_q, va_d;
    logic [27:0] base_q, base_d;
    logic [1:0]  level_q, level_d;
    logic [7:0]  timer_q, timer_d;
    logic [63:0] pte_q, pte_d;

    logic [2:0]  mode_q, mode_d;
    logic [2:0]  reg_q, reg_d;
    logic [63:0] inaddr_q, inaddr_d;
    logic [39:0] maddr_q, maddr_d;
    logic        oe_q, oe_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        fault_q, fault_d;

    logic [8:0]  idx_d;

    // Only the page-frame field of the TTB is meaningful.
    logic unused_ttb_bits;
    assign unused_ttb_bits = ^{tlbOutAddr[63:40], tlbOutAddr[11:0]};

    always_comb begin
        state_d = state_q;
        va_d    = va_q;
        base_d  = base_q;
        level_d = level_q;
        timer_d = timer_q;
        pte_d   = pte_q;
        case (state_q)
            S_IDLE: begin
                if (missReq) begin
                    va_d    = missAddr;
                    state_d = S_GETTTB;
                end
            end
            S_GETTTB: begin
                base_d  = tlbOutAddr[39:12];
                level_d = 2'd0;
                timer_d = 8'd0;
                state_d = S_MEMRD;
            end
            S_MEMRD: begin
                // timer_d is the number of MEMRD cycles spent so far, so the
                // read request is held for at most TO_CNT cycles.
                timer_d = (timer_q == 8'hFF) ? timer_q : timer_q + 8'd1;
                if (memErr) begin
                    state_d = S_SETTEA;
                end else if (memOK) begin
                    pte_d   = memData;
                    state_d = S_CHECK;
                end else if (timer_d == TO_CNT) begin
                    state_d = S_SETTEA;
                end
            end
            S_CHECK: begin
                if (!pte_q[VALID_BIT]) begin
                    state_d = S_SETTEA;
                end else if (level_q != 2'd3) begin
                    base_d  = pte_q[39:12];
                    level_d = level_q + 2'd1;
                    timer_d = 8'd0;
                    state_d = S_MEMRD;
                end else begin
                    state_d = S_SETPTEH;
                end
            end
            S_SETPTEH: state_d = S_SETPTEL;
            S_SETPTEL: state_d = S_LDTLB;
            S_LDTLB:   state_d = S_DONE;
            S_DONE:    state_d = S_IDLE;
            S_SETTEA:  state_d = S_FAULT;
            S_FAULT:   state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_comb begin
        case (level_d)
            2'd0:    idx_d = va_q[47:39];
            2'd1:    idx_d = va_q[38:30];
            2'd2:    idx_d = va_q[29:21];
            default: idx_d = va_q[20:12];
        endcase
    end

    // Outputs are registered from the next state so each one is valid in
    // the cycle of the state it belongs to.
    always_comb begin
        mode_d   = OP_NONE;
        reg_d    = R_NONE;
        inaddr_d = 64'h0;
        oe_d     = 1'b0;
        maddr_d  = maddr_q;
        busy_d   = (state_d != S_IDLE);
        done_d   = (state_d == S_DONE);
        fault_d  = (state_d == S_FAULT);
        case (state_d)
            S_GETTTB: begin
                mode_d = OP_GETREG;
                reg_d  = R_TTB;
            end
            S_MEMRD: begin
                oe_d    = 1'b1;
                maddr_d = {base_d, idx_d, 3'b000};
            end
            S_SETPTEH: begin
                mode_d   = OP_SETREG;
                reg_d    = R_PTEH;
                inaddr_d = {16'h0, va_q[47:12], 12'h000};
            end
            S_SETPTEL: begin
                mode_d   = OP_SETREG;
                reg_d    = R_PTEL;
                inaddr_d = pte_q;
            end
            S_LDTLB: begin
                mode_d = OP_LDTLB;
            end
            S_SETTEA: begin
                mode_d   = OP_SETREG;
                reg_d    = R_TEA;
                inaddr_d = va_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            va_q     <= 64'h0;
            base_q   <= 28'h0;
            level_q  <= 2'd0;
            timer_q  <= 8'd0;
            pte_q    <= 64'h0;
            mode_q   <= OP_NONE;
            reg_q    <= R_NONE;
            inaddr_q <= 64'h0;
            maddr_q  <= 40'h0;
            oe_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            va_q     <= va_d;
            base_q   <= base_d;
            level_q  <= level_d;
            timer_q  <= timer_d;
            pte_q    <= pte_d;
            mode_q   <= mode_d;
            reg_q    <= reg_d;
            inaddr_q <= inaddr_d;
            maddr_q  <= maddr_d;
            oe_q     <= oe_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            fault_q  <= fault_d;
        end
    end

    assign tlbOpMode = mode_q;
    assign tlbOpReg  = reg_q;
    assign tlbInAddr = inaddr_q;
    assign memAddr   = maddr_q;
    assign memOE     = oe_q;
    assign walkBusy  = busy_q;
    assign walkDone  = done_q;
    assign walkFault = fault_q;

endmodule

// File: tb/tb_mem_tlb_walker.sv
// tb_mem_tlb_walker
//   Randomised bench for mem_tlb_walker. A TLB/memory model answers the
//   walker; the expected read sequence, outcome and cycle timing of each
//   walk are computed from the page-table rules with plain arithmetic.

module tb_mem_tlb_walker;

    localparam int TIMEOUT = 255;
    localparam int VB      = 0;

    logic        clk = 1'b0;
    logic        reset;
    logic        missReq;
    logic [63:0] missAddr;
    logic [2:0]  tlbOpMode;
    logic [2:0]  tlbOpReg;
    logic [63:0] tlbInAddr;
    logic [63:0] tlbOutAddr;
    logic [39:0] memAddr;
    logic        memOE;
    logic [63:0] memData;
    logic        memOK;
    logic        memErr;
    logic        walkBusy;
    logic        walkDone;
    logic        walkFault;

    always #5 clk = ~clk;

    mem_tlb_walker #(.TIMEOUT(TIMEOUT), .VALID_BIT(VB)) dut (
        .clk(clk), .reset(reset), .missReq(missReq), .missAddr(missAddr),
        .tlbOpMode(tlbOpMode), .tlbOpReg(tlbOpReg), .tlbInAddr(tlbInAddr),
        .tlbOutAddr(tlbOutAddr), .memAddr(memAddr), .memOE(memOE),
        .memData(memData), .memOK(memOK), .memErr(memErr),
        .walkBusy(walkBusy), .walkDone(walkDone), .walkFault(walkFault)
    );

    // TLB register file: TTB getreg answers combinationally.
    logic [63:0] ttb_reg;
    assign tlbOutAddr = (tlbOpMode == 3'd2 && tlbOpReg == 3'd3) ? ttb_reg : 64'h0;

    logic [63:0] mem [logic [39:0]];
    int wait_l [4];
    int err_level, to_level;
    bit both_flag, pulse_en;

    int checks = 0;
    int errors = 0;

    // per-walk observations
    logic [39:0] obs_reads [$];
    logic [63:0] pteh, ptel, tea;
    int pteh_n, ptel_n, tea_n, bad_op_n, ldtlb_n, done_n, fault_n;
    int pteh_cyc, ptel_cyc, tea_cyc, ldtlb_cyc, getreg_cyc, end_cyc;
    int busy_gap, busy_hi, oe_cnt, last_oe_cnt;
    logic busy_after;
    bit rd_active, resp_now;
    logic [39:0] rd_addr;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got 0x%0h exp 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_obs();
        obs_reads.delete();
        pteh = 0; ptel = 0; tea = 0;
        pteh_n = 0; ptel_n = 0; tea_n = 0; bad_op_n = 0; ldtlb_n = 0;
        done_n = 0; fault_n = 0;
        pteh_cyc = -1; ptel_cyc = -1; tea_cyc = -1; ldtlb_cyc = -1;
        getreg_cyc = -1; end_cyc = -1;
        busy_gap = 0; busy_hi = 0; oe_cnt = 0; last_oe_cnt = 0;
        busy_after = 1'b1;
        rd_active = 0; resp_now = 0; rd_addr = 0;
        memOK = 0; memErr = 0;
    endtask

    // Called once per cycle just after the falling edge: logs TLB ops and
    // pulses, and plays the memory side for the current cycle.
    task automatic observe(input int c);
        int lvl;
        if (tlbOpMode == 3'd2 && tlbOpReg == 3'd3) getreg_cyc = c;
        if (tlbOpMode == 3'd3) begin
            case (tlbOpReg)
                3'd1:    begin pteh = tlbInAddr; pteh_cyc = c; pteh_n++; end
                3'd2:    begin ptel = tlbInAddr; ptel_cyc = c; ptel_n++; end
                3'd4:    begin tea  = tlbInAddr; tea_cyc  = c; tea_n++;  end
                default: bad_op_n++;
            endcase
        end
        if (tlbOpMode == 3'd4) begin ldtlb_n++; ldtlb_cyc = c; end
        if (walkBusy) busy_hi++;
        if (end_cyc < 0 && !walkBusy) busy_gap++;
        if (end_cyc >= 0 && c == end_cyc + 1) busy_after = walkBusy;
        if (walkDone)  begin done_n++;  end_cyc = c; end
        if (walkFault) begin fault_n++; end_cyc = c; end

        if (resp_now) begin
            memOK = 0; memErr = 0; resp_now = 0; rd_active = 0;
            chk("oe_drop", {63'h0, memOE}, 64'h0);
        end else if (memOE) begin
            if (!rd_active) begin
                rd_active = 1; rd_addr = memAddr; oe_cnt = 0;
                obs_reads.push_back(memAddr);
            end else begin
                chk("addr_hold", {24'h0, memAddr}, {24'h0, rd_addr});
            end
            oe_cnt++;
            last_oe_cnt = oe_cnt;
            lvl = obs_reads.size() - 1;
            if (lvl <= 3) begin
                if (lvl != to_level && oe_cnt == wait_l[lvl] + 1) begin
                    resp_now = 1;
                    if (lvl == err_level) begin
                        memErr  = 1;
                        memOK   = both_flag;
                        memData = {$urandom, $urandom} | 64'h1;
                    end else begin
                        memOK   = 1;
                        memData = mem.exists(rd_addr) ? mem[rd_addr] : 64'h0;
                    end
                end
            end
        end else begin
            rd_active = 0;
        end
    endtask

    // Random page table along the walk path of va.
    task automatic build_tables(input logic [63:0] va, input bit all_valid);
        logic [27:0] b;
        logic [39:0] a;
        logic [8:0]  ix;
        logic [63:0] p;
        mem.delete();
        b = ttb_reg[39:12];
        for (int l = 0; l < 4; l++) begin
            ix = 9'((va >> (39 - 9 * l)) & 64'h1FF);
            a  = {b, 12'h000} + {28'h0, ix, 3'b000};
            if (!mem.exists(a)) begin
                p = {$urandom, $urandom};
                p[VB] = all_valid ? 1'b1 : ($urandom_range(0, 7) != 0);
                mem[a] = p;
            end
            b = mem[a][39:12];
        end
    endtask

    task automatic set_plan(input int w, input int el, input int tl);
        for (int l = 0; l < 4; l++) wait_l[l] = w;
        err_level = el; to_level = tl; both_flag = 0; pulse_en = 0;
    endtask

    task automatic run_walk(input logic [63:0] va, input string nm);
        logic [27:0] b;
        logic [39:0] a;
        logic [8:0]  ix;
        logic [63:0] p, exp_pte;
        logic [39:0] exp_reads [$];
        int e, ck, exp_end, limit;
        bit exp_done;

        // reference: expected reads, outcome and end cycle (request = cycle 0)
        e = 2; b = ttb_reg[39:12]; exp_done = 0; exp_end = 0; exp_pte = 0;
        for (int l = 0; l < 4; l++) begin
            ix = 9'((va >> (39 - 9 * l)) & 64'h1FF);
            a  = {b, 12'h000} + {28'h0, ix, 3'b000};
            exp_reads.push_back(a);
            if (l == to_level)  begin exp_end = e + TIMEOUT + 1; break; end
            if (l == err_level) begin exp_end = e + wait_l[l] + 2; break; end
            p  = mem.exists(a) ? mem[a] : 64'h0;
            ck = e + 1 + wait_l[l];
            if (!p[VB]) begin exp_end = ck + 2; break; end
            if (l == 3) begin
                exp_done = 1; exp_pte = p; exp_end = ck + 4;
            end else begin
                b = p[39:12]; e = ck + 1;
            end
        end

        clear_obs();
        missReq = 1; missAddr = va;
        limit = exp_end + 10;
        for (int c = 1; c <= limit; c++) begin
            @(negedge clk);
            missReq = pulse_en && walkBusy && ($urandom_range(0, 2) == 0);
            if (c == 1) missAddr = {$urandom, $urandom};
            observe(c);
            if (end_cyc >= 0 && c >= end_cyc + 2) break;
        end
        missReq = 0;

        chk({nm, ":end_cyc"}, 64'(end_cyc), 64'(exp_end));
        chk({nm, ":done_n"}, 64'(done_n), 64'(exp_done ? 1 : 0));
        chk({nm, ":fault_n"}, 64'(fault_n), 64'(exp_done ? 0 : 1));
        chk({nm, ":getreg"}, 64'(getreg_cyc), 64'd1);
        chk({nm, ":busy_gap"}, 64'(busy_gap), 64'd0);
        chk({nm, ":busy_after"}, {63'h0, busy_after}, 64'h0);
        chk({nm, ":bad_op"}, 64'(bad_op_n), 64'd0);
        chk({nm, ":n_reads"}, 64'(obs_reads.size()), 64'(exp_reads.size()));
        foreach (exp_reads[i])
            chk($sformatf("%s:rd%0d", nm, i),
                (i < obs_reads.size()) ? {24'h0, obs_reads[i]} : 64'hFFFF_FFFF_FFFF_FFFF,
                {24'h0, exp_reads[i]});
        if (exp_done) begin
            chk({nm, ":pteh"}, pteh, {16'h0, va[47:12], 12'h000});
            chk({nm, ":ptel"}, ptel, exp_pte);
            chk({nm, ":pteh_cyc"}, 64'(pteh_cyc), 64'(exp_end - 3));
            chk({nm, ":ptel_cyc"}, 64'(ptel_cyc), 64'(exp_end - 2));
            chk({nm, ":ldtlb_cyc"}, 64'(ldtlb_cyc), 64'(exp_end - 1));
            chk({nm, ":ldtlb_n"}, 64'(ldtlb_n), 64'd1);
            chk({nm, ":tea_n"}, 64'(tea_n), 64'd0);
        end else begin
            chk({nm, ":tea"}, tea, va);
            chk({nm, ":tea_cyc"}, 64'(tea_cyc), 64'(exp_end - 1));
            chk({nm, ":ldtlb_n"}, 64'(ldtlb_n), 64'd0);
            chk({nm, ":pte_wr"}, 64'(pteh_n + ptel_n), 64'd0);
        end
        if (to_level >= 0)
            chk({nm, ":to_oe_cycles"}, 64'(last_oe_cnt), 64'(TIMEOUT));
    endtask

    task automatic spec_tables(input logic [63:0] leaf);
        mem.delete();
        ttb_reg = 64'h1000;
        mem[40'h1000 + 40'h24  * 8] = 64'h2001;
        mem[40'h2000 + 40'hD1  * 8] = 64'h3001;
        mem[40'h3000 + 40'hB3  * 8] = 64'h4001;
        mem[40'h4000 + 40'h189 * 8] = leaf;
    endtask

    localparam logic [63:0] SPEC_VA = 64'h0000_1234_5678_9ABC;

    initial begin
        logic [63:0] va;
        bit hit;
        reset = 0; missReq = 0; missAddr = 0; memData = 0;
        memOK = 0; memErr = 0; ttb_reg = 0;
        set_plan(0, -1, -1);
        repeat (3) @(negedge clk);
        chk("rst:busy",  {63'h0, walkBusy},  64'h0);
        chk("rst:done",  {63'h0, walkDone},  64'h0);
        chk("rst:fault", {63'h0, walkFault}, 64'h0);
        chk("rst:oe",    {63'h0, memOE},     64'h0);
        chk("rst:mode",  {61'h0, tlbOpMode}, 64'h0);
        chk("rst:reg",   {61'h0, tlbOpReg},  64'h0);
        chk("rst:inaddr", tlbInAddr, 64'h0);
        chk("rst:maddr", {24'h0, memAddr}, 64'h0);
        reset = 1;
        @(negedge clk);

        // good walk with the reference page table
        spec_tables(64'h00_5555_5001);
        set_plan(0, -1, -1);
        run_walk(SPEC_VA, "good");
        chk("good:a0", (obs_reads.size() > 0) ? {24'h0, obs_reads[0]} : 64'h0, 64'h1120);
        chk("good:a1", (obs_reads.size() > 1) ? {24'h0, obs_reads[1]} : 64'h0, 64'h2688);
        chk("good:a2", (obs_reads.size() > 2) ? {24'h0, obs_reads[2]} : 64'h0, 64'h3598);
        chk("good:a3", (obs_reads.size() > 3) ? {24'h0, obs_reads[3]} : 64'h0, 64'h4C48);
        chk("good:pteh_lit", pteh, 64'h0000_1234_5678_9000);
        chk("good:ptel_lit", ptel, 64'h0000_0000_5555_5001);
        chk("good:done_lit", 64'(end_cyc), 64'd13);

        spec_tables(64'h00_5555_5000);
        run_walk(SPEC_VA, "inv_leaf");

        spec_tables(64'h00_5555_5001);
        set_plan(1, 1, -1);
        run_walk(SPEC_VA, "err_l1");
        chk("err_l1:reads2", 64'(obs_reads.size()), 64'd2);

        set_plan(0, -1, 0);
        run_walk(SPEC_VA, "timeout_l0");

        spec_tables(64'h00_5555_5001);
        set_plan(2, -1, -1);
        pulse_en = 1;
        run_walk(SPEC_VA, "pulse");

        for (int n = 0; n < 30; n++) begin
            ttb_reg = {$urandom, $urandom};
            va = {$urandom, $urandom};
            build_tables(va, 0);
            for (int l = 0; l < 4; l++) wait_l[l] = $urandom_range(0, 3);
            err_level = ($urandom_range(0, 5) == 0) ? $urandom_range(0, 3) : -1;
            to_level  = -1;
            both_flag = $urandom_range(0, 1);
            pulse_en  = $urandom_range(0, 1);
            run_walk(va, $sformatf("rnd%0d", n));
        end

        ttb_reg = {$urandom, $urandom};
        va = {$urandom, $urandom};
        build_tables(va, 1);
        set_plan(1, -1, 2);
        run_walk(va, "timeout_l2");

        // reset during the level-2 read
        ttb_reg = {$urandom, $urandom};
        va = {$urandom, $urandom};
        build_tables(va, 1);
        set_plan(0, -1, 2);
        clear_obs();
        missReq = 1; missAddr = va; hit = 0;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            missReq = 0;
            observe(c);
            if (obs_reads.size() == 3 && memOE) begin hit = 1; break; end
        end
        chk("rst_mid:reach_l2", {63'h0, hit}, 64'h1);
        reset = 0;
        @(negedge clk);
        reset = 1;
        chk("rst_mid:busy",   {63'h0, walkBusy},  64'h0);
        chk("rst_mid:oe",     {63'h0, memOE},     64'h0);
        chk("rst_mid:mode",   {61'h0, tlbOpMode}, 64'h0);
        chk("rst_mid:reg",    {61'h0, tlbOpReg},  64'h0);
        chk("rst_mid:inaddr", tlbInAddr, 64'h0);
        chk("rst_mid:maddr",  {24'h0, memAddr}, 64'h0);
        chk("rst_mid:pulses", {62'h0, walkDone, walkFault}, 64'h0);
        clear_obs();
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            observe(c);
        end
        chk("rst_mid:setreg", 64'(pteh_n + ptel_n + tea_n + bad_op_n), 64'd0);
        chk("rst_mid:ldtlb", 64'(ldtlb_n), 64'd0);
        chk("rst_mid:ends", 64'(done_n + fault_n), 64'd0);
        chk("rst_mid:busy_hi", 64'(busy_hi), 64'd0);

        // walker must be usable again afterwards
        set_plan(0, -1, -1);
        run_walk(va, "post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
